csd_shift_add_mul: RTL and testbench
====================================

Name: csd_shift_add_mul

Overview:
- Downstream consumer of the CSD converter.
- Reads the converter's nonzero-digit list (digit position plus sign) and multiplies a signed operand by the CSD-encoded constant.
- Uses one shift-and-add or shift-and-subtract per nonzero digit.
- Sequential engine with a start/done handshake; feeds the filter datapath that follows.

Parameters:
- DATA_W, 8: width of signed operand x.
- DIGITS, 16: number of CSD digit positions; also the maximum list length.
- POS_W, 4: width of a digit position (clog2 DIGITS).
- ACC_W, 25: internal accumulator width (DATA_W+DIGITS+1); never overflows.
- OUT_W, 16: width of the product output.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  request a multiply; sampled only in IDLE.
- x  in  DATA_W  signed operand; captured on accepted start.
- numK  in  POS_W+1  count of valid list entries, 0..DIGITS; captured on accepted start.
- kRe  out  1  read enable to the converter's K list memory.
- kAddr  out  POS_W  list read address.
- kPos  in  POS_W  digit position; valid 1 cycle after kRe (synchronous read).
- kNeg  in  1  digit sign, 1 means -1; same timing as kPos.
- product  out  OUT_W  signed result; held until the next accepted start.
- done  out  1  one-cycle pulse when product is updated.
- busy  out  1  high in every state except IDLE.
- ovf  out  1  overflow flag (see Optional Feature).

Behaviour:
- Reset (async, reset==0): state=IDLE, product=0, done=0, busy=0, kRe=0, kAddr=0, ovf=0, acc=0, idx=0.
- FSM states: IDLE, LOAD, FETCH, ACC, DONE.
- IDLE: start=1 -> LOAD. In LOAD: latch x (sign-extended to ACC_W), latch numK, acc=0, idx=0.
- numK clamp: numK>DIGITS is clamped to DIGITS.
- LOAD -> DONE if numK==0, else -> FETCH.
- FETCH: kRe=1, kAddr=idx for exactly this cycle -> ACC.
- ACC: term = x_ext <<< kPos.
  - acc = kNeg ? acc-term : acc+term.
  - idx=idx+1.
  - -> DONE if idx+1==numK, else -> FETCH.
- DONE: product=f(acc), done=1 for this single cycle -> IDLE.
- Latency: start sampled at edge 0; done is high in the cycle after edge 2N+1 (N = clamped numK). One multiply per 2N+2 cycles.
- start while busy: ignored, no queuing.
- start held high across DONE->IDLE: a new multiply begins at the next edge.
- kRe is never asserted outside FETCH. kAddr holds its last value otherwise.
- Arithmetic is two's complement; acc is exact within ACC_W.
- Reset mid-operation: immediate return to reset values; partial result discarded, no done pulse.
- x and numK changes after acceptance have no effect on the running operation.

Optional Feature:
- Macro: CSD_MUL_SAT_EN.
- Defined:
  - product = acc saturated to the signed OUT_W range (0x7FFF / 0x8000 for OUT_W=16).
  - ovf is set in DONE when saturation occurred, and is sticky until reset or the next accepted start.
- Undefined:
  - product = acc[OUT_W-1:0] (wrap).
  - ovf is tied 0.

Decomposition:
- Package csd_pkg holds:
  - state enum (IDLE, LOAD, FETCH, ACC, DONE);
  - localparams DIGITS, POS_W;
  - digit-sign encoding constants shared with the converter (+1 / -1 / 0).
- One sub-module: csd_term_gen (combinational, shift x_ext by kPos and conditionally negate).
- The FSM and accumulator stay in the top module.

Test Plan:
- Basic two-term multiply:
  - Stimulus: x=5, numK=2, list {(3,+),(0,-)}.
  - Response: product=35; done exactly 6 cycles after start edge (cycle after edge 5); kRe high twice with kAddr 0 then 1.
- Negative operand, negative digit:
  - Stimulus: x=-4, numK=1, list {(2,-)}.
  - Response: product=16, busy low after done.
- Empty list:
  - Stimulus: numK=0, x=127.
  - Response: product=0; done in cycle after edge 1; kRe never asserted.
- Wide result, four terms:
  - Stimulus: x=3, numK=4, list {(0,+),(5,+),(9,+),(15,+)}.
  - Response without CSD_MUL_SAT_EN: product=0x8663, ovf=0.
  - Response with CSD_MUL_SAT_EN: product=0x7FFF, ovf=1.
- Busy guard and mid-operation reset:
  - Stimulus: pulse start during ACC of a 4-term op.
  - Response: ignored, single done pulse.
  - Stimulus: assert reset during FETCH.
  - Response: immediate IDLE, product=0, no done.
- Back-to-back and clamp:
  - Stimulus: start held high through two ops; numK=20.
  - Response: treated as 16 (kAddr 0..15 sweep); second op starts the edge after DONE.

Source files
------------

// File: rtl/csd_pkg.sv
// Shared types and sizes for the CSD shift-and-add multiplier and its converter.
package csd_pkg;

  localparam int DATA_W = 8;
  localparam int DIGITS = 16;
  localparam int POS_W  = $clog2(DIGITS);
  localparam int ACC_W  = DATA_W + DIGITS + 1;
  localparam int OUT_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    ACC,
    DONE
  } state_e;

  // Digit-sign encoding shared with the converter: 0, +1, -1 (two's complement).
  typedef enum logic [1:0] {
    DIG_ZERO = 2'b00,
    DIG_POS  = 2'b01,
    DIG_NEG  = 2'b11
  } digit_e;

endpackage

// File: rtl/csd_shift_add_mul_if.sv
// Handshake, operand and K-list bus between the multiplier and its neighbours.
interface csd_shift_add_mul_if;
  import csd_pkg::*;

  logic                     start;
  logic signed [DATA_W-1:0] x;
  logic [POS_W:0]           numK;
  logic                     kRe;
  logic [POS_W-1:0]         kAddr;
  logic [POS_W-1:0]         kPos;
  logic                     kNeg;
  logic signed [OUT_W-1:0]  product;
  logic                     done;
  logic                     busy;
  logic                     ovf;

  modport master (
    output start, x, numK, kPos, kNeg,
    input  kRe, kAddr, product, done, busy, ovf
  );

  modport slave (
    input  start, x, numK, kPos, kNeg,
    output kRe, kAddr, product, done, busy, ovf
  );

endinterface

// File: rtl/csd_term_gen.sv
// One partial product: the sign-extended operand shifted to a digit position, negated for a -1 digit.
module csd_term_gen
  import csd_pkg::*;
(
  input  logic signed [ACC_W-1:0] x_ext,
  input  logic [POS_W-1:0]        pos,
  input  logic                    neg,
  output logic signed [ACC_W-1:0] term
);

  digit_e                  digit;
  logic signed [ACC_W-1:0] shifted;

  assign digit   = neg ? DIG_NEG : DIG_POS;
  assign shifted = x_ext <<< pos;

  always_comb begin
    case (digit)
      DIG_POS: term = shifted;
      DIG_NEG: term = -shifted;
      default: term = '0;
    endcase
  end

endmodule

// File: rtl/csd_shift_add_mul.sv
// Sequential CSD constant multiplier: one shift-and-add/subtract per nonzero digit read from the K list.
// Optional saturation of the product and a sticky ovf flag when CSD_MUL_SAT_EN is defined.
module csd_shift_add_mul
  import csd_pkg::*;
(
  input logic                clk,
  input logic                reset,
  csd_shift_add_mul_if.slave bus
);

  localparam logic [POS_W:0] NUM_MAX = (POS_W+1)'(DIGITS);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] x_q, x_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [ACC_W-1:0] term, acc_sum;
  logic [POS_W:0]          num_q, num_d;
  logic [POS_W:0]          idx_q, idx_d, idx_inc;
  logic                    kre_q, kre_d;
  logic [POS_W-1:0]        kaddr_q, kaddr_d;
  logic [OUT_W-1:0]        prod_q, prod_d, fin_prod;
  logic                    done_q, done_d;
  logic                    busy_q, busy_d;
  logic                    last_acc;

  csd_term_gen u_term_gen (
    .x_ext (x_q),
    .pos   (bus.kPos),
    .neg   (bus.kNeg),
    .term  (term)
  );

  assign acc_sum  = acc_q + term;
  assign idx_inc  = idx_q + (POS_W+1)'(1);
  assign last_acc = (state_q == ACC) && (idx_inc == num_q);

`ifdef CSD_MUL_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  logic fin_sat;
  logic ovf_q, ovf_d;

  always_comb begin
    fin_sat = 1'b1;
    if (acc_sum > SAT_MAX) begin
      fin_prod = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (acc_sum < SAT_MIN) begin
      fin_prod = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      fin_prod = acc_sum[OUT_W-1:0];
      fin_sat  = 1'b0;
    end
  end

  // Cleared by an accepted start, set when the final accumulation saturates.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && bus.start) begin
      ovf_d = 1'b0;
    end else if (last_acc) begin
      ovf_d = ovf_q | fin_sat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign fin_prod = acc_sum[OUT_W-1:0];
  assign bus.ovf  = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a value unassigned (no latches).
    state_d = state_q;
    x_d     = x_q;
    acc_d   = acc_q;
    num_d   = num_q;
    idx_d   = idx_q;
    kre_d   = 1'b0;
    kaddr_d = kaddr_q;
    prod_d  = prod_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = LOAD;
          x_d     = {{(ACC_W-DATA_W){bus.x[DATA_W-1]}}, bus.x};
          num_d   = (bus.numK > NUM_MAX) ? NUM_MAX : bus.numK;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (num_q == '0) begin
          state_d = DONE;
          done_d  = 1'b1;
          prod_d  = '0;
        end else begin
          state_d = FETCH;
          kre_d   = 1'b1;
          kaddr_d = idx_q[POS_W-1:0];
        end
      end
      FETCH: state_d = ACC;
      ACC: begin
        acc_d = acc_sum;
        idx_d = idx_inc;
        if (last_acc) begin
          state_d = DONE;
          done_d  = 1'b1;
          prod_d  = fin_prod;
        end else begin
          state_d = FETCH;
          kre_d   = 1'b1;
          kaddr_d = idx_inc[POS_W-1:0];
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      acc_q   <= '0;
      num_q   <= '0;
      idx_q   <= '0;
      kre_q   <= 1'b0;
      kaddr_q <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q <= state_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      num_q   <= num_d;
      idx_q   <= idx_d;
      kre_q   <= kre_d;
      kaddr_q <= kaddr_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.kRe     = kre_q;
  assign bus.kAddr   = kaddr_q;
  assign bus.product = prod_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_csd_shift_add_mul.sv
// Self-checking bench for csd_shift_add_mul: directed cases plus random CSD lists against an arithmetic model.
// Honors CSD_MUL_SAT_EN for the expected product and ovf.
module tb_csd_shift_add_mul;
  import csd_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  csd_shift_add_mul_if bus();

  csd_shift_add_mul dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // K list memory with a one-cycle synchronous read.
  logic [POS_W-1:0] mem_pos [DIGITS];
  logic             mem_neg [DIGITS];

  always @(posedge clk) begin
    if (bus.kRe === 1'b1) begin
      bus.kPos <= mem_pos[bus.kAddr];
      bus.kNeg <= mem_neg[bus.kAddr];
    end
  end

  int done_total = 0;
  int addr_total[$];

  always @(negedge clk) begin
    if (bus.kRe === 1'b1) addr_total.push_back(int'(bus.kAddr));
    if (bus.done === 1'b1) done_total++;
  end

  int checks   = 0;
  int failures = 0;
  int done_base;
  int addr_base;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_result(input longint s, output logic [15:0] p, output logic o);
`ifdef CSD_MUL_SAT_EN
    if (s > 32767) begin
      p = 16'h7FFF; o = 1'b1;
    end else if (s < -32768) begin
      p = 16'h8000; o = 1'b1;
    end else begin
      p = 16'(s); o = 1'b0;
    end
`else
    p = 16'(s);
    o = 1'b0;
`endif
  endfunction

  task automatic fill_random();
    int perm[DIGITS];
    int j, tmp;
    for (int i = 0; i < DIGITS; i++) perm[i] = i;
    for (int i = DIGITS - 1; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    for (int i = 0; i < DIGITS; i++) begin
      mem_pos[i] = POS_W'(perm[i]);
      mem_neg[i] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic snapshot();
    done_base = done_total;
    addr_base = addr_total.size();
  endtask

  // Drive a start from IDLE and return just after the accepting edge.
  task automatic accept_op(input int xv, input int nk);
    bus.x     = 8'(xv);
    bus.numK  = 5'(nk);
    bus.start = 1'b1;
    snapshot();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Wait for done and verify latency, product, ovf, K-list reads and post-done state.
  task automatic finish_op(input string tag, input int xv, input int nk, input int cyc0,
                           input int inj, input bit chk_busy);
    int          n;
    int          cyc;
    int          got_n;
    bit          seen;
    bit          ok;
    longint      s;
    logic [15:0] ep;
    logic        eo;
    n    = (nk > DIGITS) ? DIGITS : nk;
    s    = 0;
    cyc  = cyc0;
    seen = 1'b0;
    for (int i = 0; i < n; i++)
      s += (mem_neg[i] ? -1 : 1) * (longint'(xv) * (longint'(1) << mem_pos[i]));
    model_result(s, ep, eo);
    for (int g = 0; g < 400 && !seen; g++) begin
      if (cyc > 0 && bus.done === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
        if (inj > 0 && cyc == inj) begin
          bus.start = 1'b1;
          bus.x     = 8'(~xv);
          bus.numK  = 5'd1;
        end else if (inj > 0 && cyc == inj + 1) begin
          bus.start = 1'b0;
        end
      end
    end
    check({tag, "_latency"}, seen ? cyc : -1, 2 * n + 2);
    check({tag, "_product"}, $unsigned(bus.product), ep);
    check({tag, "_ovf"}, bus.ovf, eo);
    @(negedge clk);
    #1;
    check({tag, "_done_pulses"}, done_total - done_base, 1);
    got_n = addr_total.size() - addr_base;
    check({tag, "_kre_count"}, got_n, n);
    ok = (got_n == n);
    for (int i = 0; i < n && ok; i++)
      if (addr_total[addr_base + i] != i) ok = 1'b0;
    check({tag, "_kaddr_seq"}, ok, 1);
    if (chk_busy) check({tag, "_busy_after"}, bus.busy, 0);
    if (n > 0) check({tag, "_kaddr_hold"}, bus.kAddr, n - 1);
    check({tag, "_product_hold"}, $unsigned(bus.product), ep);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] xr;
    int xv, x2, nk;

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.x     = '0;
    bus.numK  = '0;
    repeat (2) @(negedge clk);
    check("rst_product", $unsigned(bus.product), 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_kre", bus.kRe, 0);
    check("rst_kaddr", bus.kAddr, 0);
    check("rst_ovf", bus.ovf, 0);
    reset = 1'b1;
    @(negedge clk);
    #1;

    // Basic two-term multiply: 5 * (8 - 1).
    mem_pos[0] = 4'd3; mem_neg[0] = 1'b0;
    mem_pos[1] = 4'd0; mem_neg[1] = 1'b1;
    accept_op(5, 2);
    finish_op("two_term", 5, 2, 0, 0, 1);
    check("two_term_value", $unsigned(bus.product), 35);

    // Negative operand, negative digit: -4 * -4.
    mem_pos[0] = 4'd2; mem_neg[0] = 1'b1;
    accept_op(-4, 1);
    finish_op("neg_neg", -4, 1, 0, 0, 1);
    check("neg_neg_value", $unsigned(bus.product), 16);

    // Empty list.
    accept_op(127, 0);
    finish_op("empty", 127, 0, 0, 0, 1);

    // Wide result, four terms.
    mem_pos[0] = 4'd0;  mem_neg[0] = 1'b0;
    mem_pos[1] = 4'd5;  mem_neg[1] = 1'b0;
    mem_pos[2] = 4'd9;  mem_neg[2] = 1'b0;
    mem_pos[3] = 4'd15; mem_neg[3] = 1'b0;
    accept_op(3, 4);
    finish_op("wide", 3, 4, 0, 0, 1);
`ifdef CSD_MUL_SAT_EN
    check("wide_value", $unsigned(bus.product), 16'h7FFF);
    check("wide_ovf_value", bus.ovf, 1);
`else
    check("wide_value", $unsigned(bus.product), 16'h8663);
    check("wide_ovf_value", bus.ovf, 0);
`endif

    // Start pulse (with new x/numK) during ACC must be ignored.
    accept_op(-7, 4);
    finish_op("busy_guard", -7, 4, 0, 3, 1);

    // Reset during the second FETCH.
    accept_op(-7, 4);
    repeat (4) @(negedge clk);
    check("midrst_in_fetch", bus.kRe, 1);
    check("midrst_fetch_addr", bus.kAddr, 1);
    reset = 1'b0;
    #1;
    check("midrst_product", $unsigned(bus.product), 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_kre", bus.kRe, 0);
    check("midrst_kaddr", bus.kAddr, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_ovf", bus.ovf, 0);
    repeat (3) @(negedge clk);
    check("midrst_no_done", done_total - done_base, 0);
    reset = 1'b1;
    @(negedge clk);
    #1;

    // Back-to-back with start held high and numK clamped from 20 to 16.
    fill_random();
    xr = 8'($urandom);
    xv = $signed(xr);
    bus.x     = 8'(xv);
    bus.numK  = 5'd20;
    bus.start = 1'b1;
    snapshot();
    @(posedge clk);
    #1;
    finish_op("clamp_a", xv, 20, 0, 0, 0);
    fill_random();
    xr = 8'($urandom);
    x2 = $signed(xr);
    bus.x = 8'(x2);
    snapshot();
    @(negedge clk);
    check("b2b_restart_busy", bus.busy, 1);
    bus.start = 1'b0;
    finish_op("clamp_b", x2, 20, 1, 0, 1);

    // Random operands and CSD lists.
    for (int t = 0; t < 30; t++) begin
      fill_random();
      xr = 8'($urandom);
      xv = $signed(xr);
      nk = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
      accept_op(xv, nk);
      finish_op($sformatf("rand%0d", t), xv, nk, 0, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
